dbg_guv_log_arb: RTL and testbench



---
 rtl/dbg_guv_log_arb.sv | 170 +++++++++++++++++
 tb/tb_dbg_guv_log_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_guv_log_arb.sv
// rtl/dbg_guv_log_arb.sv - packet-aware round-robin merge of dbg_guv log streams into one uplink
// Defining DBG_GUV_LOG_ARB_HDR_EN prepends a per-source sequence header flit to every packet.
module dbg_guv_log_arb #(
  parameter int N_IN       = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = $clog2(N_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN*DATA_WIDTH-1:0]   logs_TDATA,
  input  logic [N_IN-1:0]              logs_TVALID,
  input  logic [N_IN-1:0]              logs_TLAST,
  output logic [N_IN-1:0]              logs_TREADY,
  output logic [DATA_WIDTH-1:0]        out_TDATA,
  output logic                         out_TVALID,
  output logic                         out_TLAST,
  output logic [SEL_WIDTH-1:0]         out_TID,
  input  logic                         out_TREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS
`ifdef DBG_GUV_LOG_ARB_HDR_EN
    , S_HDR
`endif
  } state_t;

  localparam logic [SEL_WIDTH:0] N_IN_W = (SEL_WIDTH+1)'(N_IN);

  state_t                 state, state_nxt;
  logic [SEL_WIDTH-1:0]   grant, ptr;
  logic [DATA_WIDTH-1:0]  src_data [N_IN];

  logic                   scan_found;
  logic [SEL_WIDTH-1:0]   scan_idx;
  logic [SEL_WIDTH:0]     cand;

  logic [DATA_WIDTH-1:0]  sb_data [2];
  logic                   sb_last [2];
  logic [SEL_WIDTH-1:0]   sb_tid  [2];
  logic                   sb_rd, sb_wr;
  logic [1:0]             sb_cnt;
  logic                   sb_full, push, pop;
  logic [DATA_WIDTH-1:0]  push_data;
  logic                   push_last;
  logic                   acc_in, acc_last;

  for (genvar i = 0; i < N_IN; i++) begin : g_src
    assign src_data[i] = logs_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef DBG_GUV_LOG_ARB_HDR_EN
  logic [7:0] seq [N_IN];
  logic [7:0] hdr_src;
  assign hdr_src = 8'(grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) seq[i] <= 8'd0;
    end else if (acc_last) begin
      seq[grant] <= seq[grant] + 8'd1;
    end
  end
`endif

  // Fullness comes only from the registered occupancy, keeping upstream ready off the uplink path.
  assign sb_full    = (sb_cnt == 2'd2);
  assign pop        = (sb_cnt != 2'd0) && out_TREADY;
  assign out_TVALID = (sb_cnt != 2'd0);
  assign out_TDATA  = sb_data[sb_rd];
  assign out_TLAST  = sb_last[sb_rd];
  assign out_TID    = sb_tid[sb_rd];

  // Iterate from the far end so the candidate closest to ptr wins.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int k = N_IN-1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
      if (cand >= N_IN_W) cand = cand - N_IN_W;
      if (logs_TVALID[cand[SEL_WIDTH-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = cand[SEL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (scan_found) begin
`ifdef DBG_GUV_LOG_ARB_HDR_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_PASS;
`endif
        end
      end
`ifdef DBG_GUV_LOG_ARB_HDR_EN
      S_HDR:   if (!sb_full) state_nxt = S_PASS;
`endif
      S_PASS:  if (acc_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    logs_TREADY = '0;
    acc_in      = 1'b0;
    acc_last    = 1'b0;
    push        = 1'b0;
    push_data   = src_data[grant];
    push_last   = logs_TLAST[grant];
    if (state == S_PASS) begin
      logs_TREADY[grant] = !sb_full;
      acc_in             = logs_TVALID[grant] && !sb_full;
      acc_last           = acc_in && logs_TLAST[grant];
      push               = acc_in;
    end
`ifdef DBG_GUV_LOG_ARB_HDR_EN
    if (state == S_HDR) begin
      push      = !sb_full;
      push_data = {16'hDB60, seq[grant], hdr_src};
      push_last = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      ptr   <= '0;
    end else begin
      if (state == S_IDLE && scan_found) grant <= scan_idx;
      if (acc_last) ptr <= (grant == SEL_WIDTH'(N_IN-1)) ? '0 : grant + 1'b1;
    end
  end

  // Two-entry ring; a push never lands on the head while it is valid, so out_* hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_rd  <= 1'b0;
      sb_wr  <= 1'b0;
      sb_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        sb_data[i] <= '0;
        sb_last[i] <= 1'b0;
        sb_tid[i]  <= '0;
      end
    end else begin
      if (push) begin
        sb_data[sb_wr] <= push_data;
        sb_last[sb_wr] <= push_last;
        sb_tid[sb_wr]  <= grant;
        sb_wr          <= ~sb_wr;
      end
      if (pop) sb_rd <= ~sb_rd;
      sb_cnt <= sb_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dbg_guv_log_arb.sv
// tb/tb_dbg_guv_log_arb.sv - scoreboard bench for dbg_guv_log_arb (4-input and 3-input instances)
module tb_dbg_guv_log_arb;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int SW    = 2;
  localparam int DEPTH = 512;
`ifdef DBG_GUV_LOG_ARB_HDR_EN
  localparam int HDR_CYC = 1;
`else
  localparam int HDR_CYC = 0;
`endif

  logic             clk;
  logic             rst;
  logic [N*W-1:0]   logs_TDATA;
  logic [N-1:0]     logs_TVALID, logs_TLAST, logs_TREADY;
  logic [W-1:0]     out_TDATA;
  logic             out_TVALID, out_TLAST, out_TREADY;
  logic [SW-1:0]    out_TID;

  logic [3*W-1:0]   l3_TDATA;
  logic [2:0]       l3_TVALID, l3_TLAST, l3_TREADY;
  logic [W-1:0]     o3_TDATA;
  logic             o3_TVALID, o3_TLAST, o3_TREADY;
  logic [1:0]       o3_TID;

  dbg_guv_log_arb #(.N_IN(N), .DATA_WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .logs_TDATA(logs_TDATA), .logs_TVALID(logs_TVALID), .logs_TLAST(logs_TLAST),
    .logs_TREADY(logs_TREADY),
    .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TLAST(out_TLAST),
    .out_TID(out_TID), .out_TREADY(out_TREADY)
  );

  dbg_guv_log_arb #(.N_IN(3), .DATA_WIDTH(W)) u_dut3 (
    .clk(clk), .rst(rst),
    .logs_TDATA(l3_TDATA), .logs_TVALID(l3_TVALID), .logs_TLAST(l3_TLAST),
    .logs_TREADY(l3_TREADY),
    .out_TDATA(o3_TDATA), .out_TVALID(o3_TVALID), .out_TLAST(o3_TLAST),
    .out_TID(o3_TID), .out_TREADY(o3_TREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W:0]      src_mem [N][DEPTH];
  int              src_wr [N];
  int              src_rd [N];
  logic [SW+W:0]   exp_q [$];
  int              tid3_q [$];
  int              pkt_id = 0;
  int              occ_m = 0;
  bit              in_pkt = 0;
  int              pkt_src = 0;
  int              first_xfer = -1;
  int              last_xfer = 0;
  bit              saw_bp = 0;
`ifdef DBG_GUV_LOG_ARB_HDR_EN
  logic [7:0]      seq_m [N];
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input int s, input int len);
    logic [W-1:0] d;
    logic         last;
`ifdef DBG_GUV_LOG_ARB_HDR_EN
    exp_q.push_back({SW'(s), 1'b0, 16'hDB60, seq_m[s], 8'(s)});
    seq_m[s] = seq_m[s] + 8'd1;
`endif
    for (int f = 0; f < len; f++) begin
      d    = {8'(s) + 8'hA0, 8'(pkt_id), 16'(f)};
      last = (f == len - 1);
      src_mem[s][src_wr[s] % DEPTH] = {last, d};
      src_wr[s]++;
      exp_q.push_back({SW'(s), last, d});
    end
    pkt_id++;
  endtask

  function automatic bit busy();
    bit b;
    b = (logs_TVALID != '0);
    for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (c < budget && (exp_q.size() != 0 || busy())) begin
      @(negedge clk);
      c++;
    end
    chk("drain_in_time", 64'(c < budget), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  // Source models: present the head of each queue, pop on handshake.
  initial begin
    logic [N-1:0] acc;
    logs_TVALID = '0;
    logs_TLAST  = '0;
    logs_TDATA  = '0;
    forever begin
      @(negedge clk);
      acc = logs_TVALID & logs_TREADY;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) src_rd[i]++;
        if (src_rd[i] != src_wr[i]) begin
          logs_TVALID[i] = 1'b1;
          {logs_TLAST[i], logs_TDATA[i*W +: W]} = src_mem[i][src_rd[i] % DEPTH];
        end else begin
          logs_TVALID[i] = 1'b0;
          logs_TLAST[i]  = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, scoreboard pop and occupancy model.
  initial begin
    logic          stall_prev;
    logic [SW+W:0] held, got, e;
    logic [N-1:0]  acc;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {out_TID, out_TLAST, out_TDATA};
      if (rst) begin
        chk("rst_tready", 64'(logs_TREADY), 64'(0));
        chk("rst_tvalid", 64'(out_TVALID), 64'(0));
        chk("rst_out", 64'(got), 64'(0));
        occ_m = 0;
        in_pkt = 0;
        stall_prev = 1'b0;
      end else begin
        chk("tready_onehot", 64'($countones(logs_TREADY) <= 1), 64'(1));
        if (stall_prev) begin
          chk("stall_valid", 64'(out_TVALID), 64'(1));
          chk("stall_hold", 64'(got), 64'(held));
        end
        if (out_TVALID && out_TREADY) begin
          chk("sb_pending", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_flit", 64'(got), 64'(e));
          end
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
        end
`ifndef DBG_GUV_LOG_ARB_HDR_EN
        chk("tvalid_vs_occ", 64'(out_TVALID), 64'(occ_m != 0));
        if (logs_TREADY != '0) chk("tready_not_full", 64'(occ_m < 2), 64'(1));
        if (in_pkt && occ_m < 2) chk("tready_granted", 64'(logs_TREADY[pkt_src]), 64'(1));
`endif
        if (in_pkt && pkt_src == 3 && logs_TVALID[3] && !logs_TREADY[3]) saw_bp = 1'b1;
        acc = logs_TVALID & logs_TREADY;
        occ_m = occ_m + int'(acc != '0) - int'(out_TVALID && out_TREADY);
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            in_pkt  = !logs_TLAST[i];
            pkt_src = i;
          end
        end
        stall_prev = out_TVALID && !out_TREADY;
        held = got;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst3_tready", 64'(l3_TREADY), 64'(0));
      chk("rst3_tvalid", 64'(o3_TVALID), 64'(0));
    end else if (o3_TVALID && o3_TREADY) begin
      tid3_q.push_back(int'(o3_TID));
      chk("wrap_tid_range", 64'(o3_TID < 2'd3), 64'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int            c;
    logic [7:0]    bp_pat;
    int            exp3 [$];
    rst        = 1'b1;
    out_TREADY = 1'b1;
    o3_TREADY  = 1'b1;
    l3_TVALID  = '0;
    l3_TLAST   = '1;
    l3_TDATA   = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    bp_pat     = 8'b1001_1001;
`ifdef DBG_GUV_LOG_ARB_HDR_EN
    for (int s = 0; s < N; s++) seq_m[s] = 8'd0;
    exp3 = '{2, 2, 0, 0};
`else
    exp3 = '{2, 0};
`endif

    // Reset held while every source is valid; this traffic becomes the fairness run.
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) send_pkt(s, 2);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    c = 0;
    while (logs_TREADY == '0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("first_grant", 64'(logs_TREADY), 64'(4'b0001));
    wait_drain(200);
    chk("fair_span", 64'(last_xfer - first_xfer), 64'((3 + HDR_CYC) * 8 - 2));

    // Source 0 becomes valid while source 1 is mid-packet.
    send_pkt(1, 5);
    repeat (3) @(negedge clk);
    send_pkt(0, 2);
    wait_drain(100);

    // Backpressure during a source-3 packet.
    saw_bp = 1'b0;
    send_pkt(3, 6);
    c = 0;
    while (!out_TVALID && c < 20) begin
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 out_TREADY = bp_pat[k];
    end
    @(posedge clk);
    #1 out_TREADY = 1'b1;
    wait_drain(100);
    chk("bp_tready_dropped", 64'(saw_bp), 64'(1));

    // Back-to-back single-flit packets from one source; also wraps the header sequence.
    first_xfer = -1;
    for (int p = 0; p < 260; p++) send_pkt(0, 1);
    wait_drain(2000);
    chk("single_span", 64'(last_xfer - first_xfer), 64'((2 + HDR_CYC) * 260 - 2));

    // Three-input instance: source 2 then source 0, pointer must wrap to 0.
    l3_TVALID = 3'b100;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      if (l3_TREADY[2]) break;
      c++;
    end
    @(posedge clk);
    #1 l3_TVALID = 3'b001;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      if (l3_TREADY[0]) break;
      c++;
    end
    @(posedge clk);
    #1 l3_TVALID = 3'b000;
    repeat (6) @(negedge clk);
    chk("wrap_count", 64'(tid3_q.size()), 64'(exp3.size()));
    for (int i = 0; i < exp3.size(); i++) begin
      if (i < tid3_q.size()) chk("wrap_tid", 64'(tid3_q[i]), 64'(exp3[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
